// File: rtl/key_reader.sv
// key_reader: reads one active-low push-button on CLOCK_50.
// The raw KEY is synchronised, debounced and classified as a short or long press.
//
// Ports:
//   CLOCK_50      - system clock, rising edge
//   RESET_N       - asynchronous active-low reset
//   KEY           - raw asynchronous button, 0 = pressed
//   pressed       - debounced level, 1 while a press is accepted
//   press_pulse   - one cycle high on an accepted press
//   release_pulse - one cycle high on an accepted release
//   long_pulse    - one cycle high when the hold reaches LONG_CYCLES
//   short_pulse   - one cycle high with release_pulse if no long_pulse fired during that press
//   toggle        - inverts on every accepted press
//   press_count   - accepted press count, wraps 255 -> 0
module key_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       short_pulse,
    output logic       toggle,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

    // Hold counter stops at LONG_CYCLES so a very long hold cannot wrap
    // back around to the long-press threshold.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == LONG_MAX) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    state_t           state_q,   state_d;
    logic [1:0]       sync_q,    sync_d;
    logic [CNT_W-1:0] dcnt_q,    dcnt_d;
    logic [CNT_W-1:0] hcnt_q,    hcnt_d;
    logic             long_seen_q, long_seen_d;
    logic             pressed_q, pressed_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             long_q,    long_d;
    logic             short_q,   short_d;
    logic             toggle_q,  toggle_d;
    logic [7:0]       count_q,   count_d;

    logic key_s;
    logic long_hit;

    assign key_s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], KEY};
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_seen_d = long_seen_q;
        pressed_d   = pressed_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        short_d     = 1'b0;
        toggle_d    = toggle_q;
        count_d     = count_q;

        // The hold timer keeps running while a release is being debounced,
        // so the long threshold can still be crossed in DEB_RELEASE.
        long_hit = ((state_q == HELD) || (state_q == DEB_RELEASE)) &&
                   (hcnt_q == LONG_LAST) && !long_seen_q;

        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    dcnt_d  = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    pressed_d   = 1'b1;
                    count_d     = count_q + 8'd1;
                    toggle_d    = ~toggle_q;
                    hcnt_d      = '0;
                    long_seen_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                hcnt_d = sat_inc(hcnt_q);
                if (long_hit) begin
                    long_d      = 1'b1;
                    long_seen_d = 1'b1;
                end
                if (key_s) begin
                    dcnt_d  = '0;
                    state_d = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                hcnt_d = sat_inc(hcnt_q);
                if (long_hit) begin
                    long_d      = 1'b1;
                    long_seen_d = 1'b1;
                end
                if (!key_s) begin
                    state_d = HELD;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    pressed_d = 1'b0;
                    // A long pulse in this very cycle also suppresses short.
                    short_d   = !(long_seen_q || long_hit);
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_seen_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            short_q     <= 1'b0;
            toggle_q    <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_seen_q <= long_seen_d;
            pressed_q   <= pressed_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            short_q     <= short_d;
            toggle_q    <= toggle_d;
            count_q     <= count_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign short_pulse   = short_q;
    assign toggle        = toggle_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_key_reader.sv
// Testbench for key_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Reference model: the debounced level flips once the synchronised key has
// disagreed with it for DEBOUNCE_CYCLES+1 consecutive clock edges; the long
// event fires LONG_CYCLES edges after the accepted press.
module tb_key_reader;

    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic       pressed, press_pulse, release_pulse, long_pulse, short_pulse, toggle;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    key_reader #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (8)
    ) dut (
        .CLOCK_50     (clk),
        .RESET_N      (rst_n),
        .KEY          (key),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .short_pulse  (short_pulse),
        .toggle       (toggle),
        .press_count  (press_count)
    );

    always #10 clk = ~clk;

    // model state
    logic       m_k1, m_k2, m_lvl, m_long_seen, m_tog;
    int         m_run, m_hold;
    logic [7:0] m_cnt;
    logic       e_press, e_rel, e_long, e_short;

    function automatic logic [13:0] obs_vec();
        return {pressed, press_pulse, release_pulse, long_pulse, short_pulse, toggle, press_count};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_lvl, e_press, e_rel, e_long, e_short, m_tog, m_cnt};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_k1 = 1'b1; m_k2 = 1'b1; m_lvl = 1'b0; m_long_seen = 1'b0; m_tog = 1'b0;
        m_run = 0; m_hold = 0; m_cnt = 8'd0;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_short = 1'b0;
    endtask

    // One clock edge of the model; v is the KEY value sampled at that edge.
    task automatic model_edge(input logic v);
        logic ks;
        ks   = m_k2;
        m_k2 = m_k1;
        m_k1 = v;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_short = 1'b0;
        if (m_lvl) begin
            m_hold++;
            if (m_hold == L && !m_long_seen) begin
                e_long      = 1'b1;
                m_long_seen = 1'b1;
            end
        end
        if ((!ks) != m_lvl) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
            m_run = 0;
            m_lvl = !ks;
            if (m_lvl) begin
                e_press     = 1'b1;
                m_cnt       = m_cnt + 8'd1;
                m_tog       = !m_tog;
                m_hold      = 0;
                m_long_seen = 1'b0;
            end else begin
                e_rel   = 1'b1;
                e_short = !m_long_seen;
            end
        end
    endtask

    // Drive KEY for one cycle, advance the model and compare all outputs.
    task automatic cyc(input logic v);
        key = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check("cycle", {2'b00, obs_vec()}, {2'b00, exp_vec()});
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("in_reset", {2'b00, obs_vec()}, 16'd0);
        end
    endtask

    int lat, press_edge, long_edge, long_n, short_at_rel;

    initial begin
        rst_n = 1'b0;
        key   = 1'b1;
        model_reset();

        // Reset held 10 cycles with key released, then idle 50 cycles.
        reset_cycles(10);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 50; i++) cyc(1'b1);
        check("idle_count", {8'd0, press_count}, 16'd0);

        // Clean press: 10 low, 20 high.
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0);
            if (press_pulse && lat < 0) lat = i - 1;
        end
        check("press_latency", 16'(lat), 16'd6);
        check("clean_pressed", {15'd0, pressed}, 16'd1);
        for (int i = 0; i < 20; i++) cyc(1'b1);
        check("clean_count", {8'd0, press_count}, 16'd1);
        check("clean_toggle", {15'd0, toggle}, 16'd1);

        // Press bounce rejected.
        cyc(1'b0); cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1);
        check("bounce_count", {8'd0, press_count}, 16'd1);

        // Release bounce inside HELD: one press only.
        for (int i = 0; i < 10; i++) cyc(1'b0);
        cyc(1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1);
        check("rel_bounce_count", {8'd0, press_count}, 16'd2);

        // Long press: 40 low then release.
        press_edge = -1; long_edge = -1; long_n = 0; short_at_rel = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b0);
            if (press_pulse) press_edge = i;
            if (long_pulse) begin long_edge = i; long_n++; end
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            if (long_pulse) long_n++;
            if (release_pulse) short_at_rel = int'(short_pulse);
        end
        check("long_gap", 16'(long_edge - press_edge), 16'(L));
        check("long_once", 16'(long_n), 16'd1);
        check("long_no_short", 16'(short_at_rel), 16'd0);

        // Counter wrap after a reset: 256 clean presses.
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", {2'b00, obs_vec()}, 16'd0);
        reset_cycles(2);
        rst_n = 1'b1;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 8; i++) cyc(1'b0);
            for (int i = 0; i < 8; i++) cyc(1'b1);
        end
        check("wrap_count", {8'd0, press_count}, 16'd0);
        check("wrap_toggle", {15'd0, toggle}, 16'd0);

        // Reset mid-press with key held low.
        for (int i = 0; i < 10; i++) cyc(1'b0);
        check("held_before_reset", {15'd0, pressed}, 16'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_press_reset", {2'b00, obs_vec()}, 16'd0);
        reset_cycles(3);
        rst_n = 1'b1;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0);
            if (press_pulse && lat < 0) lat = i - 1;
        end
        check("reset_press_latency", 16'(lat), 16'd6);
        check("reset_press_count", {8'd0, press_count}, 16'd1);
        for (int i = 0; i < 10; i++) cyc(1'b1);

        // Random segments against the model.
        for (int s = 0; s < 300; s++) begin
            int len;
            logic lvl;
            lvl = s[0];
            if ($urandom_range(9, 0) == 0) len = int'($urandom_range(45, 30));
            else len = int'($urandom_range(12, 1));
            for (int i = 0; i < len; i++) cyc(lvl);
        end
        for (int i = 0; i < 30; i++) cyc(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
